// File: rtl/parking_lot_monitor.sv
// Parking-lot occupancy core.
// Two synchronized beam sensors (a = outer, b = inner) are decoded by a
// direction FSM into one-cycle entry/exit pulses. A saturating BCD counter
// tracks occupancy and six active-low 7-segment digits show CLEAr0, FULLnn
// or the plain count.
//
// Handshake: there is no valid/ready flow here. incr/decr are single-cycle
// registered strobes, never high together. The counter consumes a strobe on
// the edge after it appears, so the count moves one cycle after the pulse.
module parking_lot_monitor #(
  parameter int CAPACITY = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  output logic       incr,
  output logic       decr,
  output logic       clear,
  output logic       full,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [6:0] hex5,
  output logic [6:0] hex4,
  output logic [6:0] hex3,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EN_A  = 3'd1,
    EN_AB = 3'd2,
    EN_B  = 3'd3,
    EX_B  = 3'd4,
    EX_AB = 3'd5,
    EX_A  = 3'd6
  } state_e;

  localparam logic [3:0] CAP_TENS = 4'(CAPACITY / 10);
  localparam logic [3:0] CAP_ONES = 4'(CAPACITY % 10);

  // Active-low segment codes, bit0 = seg a ... bit6 = seg g.
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_U     = 7'h41;
  localparam logic [6:0] SEG_ZERO  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  state_e     state_q, state_d;
  logic       incr_q, incr_d;
  logic       decr_q, decr_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic [1:0] ab;

  assign ab = {a, b};

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Direction FSM next state; a pulse is armed only when 00 ends a complete pass.
  always_comb begin
    state_d = state_q;
    incr_d  = 1'b0;
    decr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        case (ab)
          2'b10:   state_d = EN_A;
          2'b01:   state_d = EX_B;
          default: state_d = IDLE;
        endcase
      end
      EN_A: begin
        case (ab)
          2'b10:   state_d = EN_A;
          2'b11:   state_d = EN_AB;
          2'b01:   state_d = EX_B;
          default: state_d = IDLE;
        endcase
      end
      EN_AB: begin
        case (ab)
          2'b11:   state_d = EN_AB;
          2'b01:   state_d = EN_B;
          2'b10:   state_d = EN_A;
          default: state_d = IDLE;
        endcase
      end
      EN_B: begin
        case (ab)
          2'b01:   state_d = EN_B;
          2'b11:   state_d = EN_AB;
          2'b10:   state_d = EN_A;
          default: begin
            state_d = IDLE;
            incr_d  = 1'b1;
          end
        endcase
      end
      EX_B: begin
        case (ab)
          2'b01:   state_d = EX_B;
          2'b11:   state_d = EX_AB;
          2'b10:   state_d = EN_A;
          default: state_d = IDLE;
        endcase
      end
      EX_AB: begin
        case (ab)
          2'b11:   state_d = EX_AB;
          2'b10:   state_d = EX_A;
          2'b01:   state_d = EX_B;
          default: state_d = IDLE;
        endcase
      end
      EX_A: begin
        case (ab)
          2'b10:   state_d = EX_A;
          2'b11:   state_d = EX_AB;
          2'b01:   state_d = EX_B;
          default: begin
            state_d = IDLE;
            decr_d  = 1'b1;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered entry/exit strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      incr_q  <= 1'b0;
      decr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      incr_q  <= incr_d;
      decr_q  <= decr_d;
    end
  end

  assign incr      = incr_q;
  assign decr      = decr_q;
  assign dbg_state = state_q;
  assign ones      = ones_q;
  assign tens      = tens_q;
  assign clear     = (ones_q == 4'd0) && (tens_q == 4'd0);
  assign full      = (ones_q == CAP_ONES) && (tens_q == CAP_TENS);

  // Saturating BCD count: strobes at the limits are dropped, never wrapped.
  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (incr_q && !full) begin
      if (ones_q >= 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (decr_q && !clear) begin
      if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  // Occupancy count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  // Display mux: clear wins over full so an empty lot always reads CLEAr0.
  always_comb begin
    hex5 = SEG_BLANK;
    hex4 = SEG_BLANK;
    hex3 = SEG_BLANK;
    hex2 = SEG_BLANK;
    hex1 = (tens_q == 4'd0) ? SEG_BLANK : seg_digit(tens_q);
    hex0 = seg_digit(ones_q);
    if (clear) begin
      hex5 = SEG_C;
      hex4 = SEG_L;
      hex3 = SEG_E;
      hex2 = SEG_A;
      hex1 = SEG_R;
      hex0 = SEG_ZERO;
    end else if (full) begin
      hex5 = SEG_F;
      hex4 = SEG_U;
      hex3 = SEG_L;
      hex2 = SEG_L;
    end
  end

endmodule

// File: tb/tb_parking_lot_monitor.sv
// Bench for parking_lot_monitor: directed vector table, hand-written
// corner sequences and randomized passes against a sensor-history model.
module tb_parking_lot_monitor;

  localparam int CAP = 25;

  logic       clk = 1'b0;
  logic       reset;
  logic       a, b;
  logic       incr, decr, clear, full;
  logic [3:0] ones, tens;
  logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int n_incr_seen = 0;
  int n_decr_seen = 0;

  // Reference model: occupancy, pulses visible now, pass direction
  // (0 none, 1 entering, 2 exiting) and the previous sensor sample.
  int         m_count;
  bit         m_incr, m_decr;
  int         m_dir;
  logic [1:0] m_prev;
  logic [1:0] exp_q[$];

  typedef struct {
    logic [1:0] ab;
    logic       exp_incr;
    logic       exp_decr;
    int         exp_count;
  } vec_t;
  vec_t vecs[$];

  parking_lot_monitor #(.CAPACITY(CAP)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .incr(incr), .decr(decr), .clear(clear), .full(full),
    .ones(ones), .tens(tens),
    .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic model_reset();
    m_count = 0;
    m_incr  = 1'b0;
    m_decr  = 1'b0;
    m_dir   = 0;
    m_prev  = 2'b00;
    exp_q.delete();
  endtask

  // One rising edge: last cycle's pulse moves the count, then the new sample
  // is judged against the direction in which the pass started.
  task automatic model_edge(input logic [1:0] s);
    if (m_incr && m_count < CAP) m_count++;
    if (m_decr && m_count > 0)   m_count--;
    m_incr = 1'b0;
    m_decr = 1'b0;
    case (s)
      2'b00: begin
        m_incr = (m_dir == 1) && (m_prev == 2'b01);
        m_decr = (m_dir == 2) && (m_prev == 2'b10);
        m_dir  = 0;
      end
      2'b11: ;
      default: begin
        if (s != m_prev && !(m_prev == 2'b11 && m_dir != 0))
          m_dir = (s == 2'b10) ? 1 : 2;
      end
    endcase
    m_prev = s;
    if (m_incr || m_decr) exp_q.push_back({m_incr, m_decr});
  endtask

  task automatic check_all();
    logic [6:0] e5, e4, e3, e2, e1, e0;
    int t, o;
    t = m_count / 10;
    o = m_count % 10;
    if (m_count == 0) begin
      e5 = 7'h46; e4 = 7'h47; e3 = 7'h06; e2 = 7'h08; e1 = 7'h2F; e0 = 7'h40;
    end else begin
      e5 = 7'h7F; e4 = 7'h7F; e3 = 7'h7F; e2 = 7'h7F;
      if (m_count == CAP) begin
        e5 = 7'h0E; e4 = 7'h41; e3 = 7'h47; e2 = 7'h47;
      end
      e1 = (t == 0) ? 7'h7F : seg_of(t);
      e0 = seg_of(o);
    end
    check("incr", incr, m_incr);
    check("decr", decr, m_decr);
    check("ones", ones, o);
    check("tens", tens, t);
    check("clear", clear, m_count == 0);
    check("full", full, m_count == CAP);
    check("hex5", hex5, e5);
    check("hex4", hex4, e4);
    check("hex3", hex3, e3);
    check("hex2", hex2, e2);
    check("hex1", hex1, e1);
    check("hex0", hex0, e0);
    if (incr === 1'b1 || decr === 1'b1) begin
      if (exp_q.size() == 0) check("pulse_unexpected", {incr, decr}, 2'b00);
      else check("pulse_event", {incr, decr}, exp_q.pop_front());
    end
  endtask

  // driver: present a sample, clock it, advance the model and compare
  task automatic step(input logic [1:0] s);
    a = s[1];
    b = s[0];
    @(posedge clk);
    #1;
    model_edge(s);
    if (incr === 1'b1) n_incr_seen++;
    if (decr === 1'b1) n_decr_seen++;
    check_all();
  endtask

  task automatic pass3(input logic [1:0] p0, input logic [1:0] p1, input logic [1:0] p2,
                       input bit rnd);
    int r;
    r = rnd ? $urandom_range(1, 2) : 1;
    for (int i = 0; i < r; i++) step(p0);
    r = rnd ? $urandom_range(1, 2) : 1;
    for (int i = 0; i < r; i++) step(p1);
    r = rnd ? $urandom_range(1, 2) : 1;
    for (int i = 0; i < r; i++) step(p2);
    step(2'b00);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_state", dbg_state, 3'd0);
    check_all();
    @(posedge clk);
    @(posedge clk);
    #2;
    a = 1'b0;
    b = 1'b0;
    reset = 1'b1;
  endtask

  task automatic add_vec(input logic [1:0] ab, input logic i, input logic d, input int c);
    vec_t v;
    v.ab = ab; v.exp_incr = i; v.exp_decr = d; v.exp_count = c;
    vecs.push_back(v);
  endtask

  initial begin
    a = 1'b0;
    b = 1'b0;
    reset = 1'b1;
    model_reset();

    // pedestrian, entry, exit, backtrack, exit at zero, back-to-back entries
    add_vec(2'b10, 0, 0, 0); add_vec(2'b01, 0, 0, 0); add_vec(2'b00, 0, 0, 0);
    add_vec(2'b10, 0, 0, 0); add_vec(2'b11, 0, 0, 0); add_vec(2'b01, 0, 0, 0);
    add_vec(2'b00, 1, 0, 0); add_vec(2'b00, 0, 0, 1);
    add_vec(2'b01, 0, 0, 1); add_vec(2'b11, 0, 0, 1); add_vec(2'b10, 0, 0, 1);
    add_vec(2'b00, 0, 1, 1); add_vec(2'b00, 0, 0, 0);
    add_vec(2'b10, 0, 0, 0); add_vec(2'b11, 0, 0, 0); add_vec(2'b10, 0, 0, 0);
    add_vec(2'b00, 0, 0, 0); add_vec(2'b00, 0, 0, 0);
    add_vec(2'b01, 0, 0, 0); add_vec(2'b11, 0, 0, 0); add_vec(2'b10, 0, 0, 0);
    add_vec(2'b00, 0, 1, 0); add_vec(2'b00, 0, 0, 0);
    add_vec(2'b10, 0, 0, 0); add_vec(2'b11, 0, 0, 0); add_vec(2'b01, 0, 0, 0);
    add_vec(2'b00, 1, 0, 0); add_vec(2'b10, 0, 0, 1); add_vec(2'b11, 0, 0, 1);
    add_vec(2'b01, 0, 0, 1); add_vec(2'b00, 1, 0, 1); add_vec(2'b00, 0, 0, 2);

    // reset state and CLEAr0
    do_reset();
    step(2'b00);
    check("rst_count", {tens, ones}, 8'h00);
    check("rst_clear", clear, 1'b1);
    check("rst_hex", {hex5, hex4, hex3, hex2, hex1, hex0},
          {7'h46, 7'h47, 7'h06, 7'h08, 7'h2F, 7'h40});

    // vector table
    foreach (vecs[i]) begin
      step(vecs[i].ab);
      check($sformatf("vec%0d_incr", i), incr, vecs[i].exp_incr);
      check($sformatf("vec%0d_decr", i), decr, vecs[i].exp_decr);
      check($sformatf("vec%0d_count", i), tens * 10 + ones, vecs[i].exp_count);
    end

    // five entries then five exits
    do_reset();
    n_incr_seen = 0;
    for (int i = 0; i < 5; i++) pass3(2'b10, 2'b11, 2'b01, 1'b0);
    step(2'b00);
    check("five_incr_pulses", n_incr_seen, 5);
    check("five_in_ones", ones, 4'd5);
    check("five_in_tens", tens, 4'd0);
    check("five_in_hex1", hex1, 7'h7F);
    check("five_in_hex0", hex0, 7'h12);
    check("five_in_clear", clear, 1'b0);
    n_decr_seen = 0;
    for (int i = 0; i < 5; i++) pass3(2'b01, 2'b11, 2'b10, 1'b0);
    step(2'b00);
    check("five_decr_pulses", n_decr_seen, 5);
    check("five_out_clear", clear, 1'b1);

    // fill to capacity, then one more entry is ignored
    for (int i = 0; i < CAP; i++) pass3(2'b10, 2'b11, 2'b01, 1'b0);
    step(2'b00);
    check("cap_full", full, 1'b1);
    pass3(2'b10, 2'b11, 2'b01, 1'b0);
    check("cap_extra_incr", incr, 1'b1);
    step(2'b00);
    check("cap_count", {tens, ones}, 8'h25);
    check("cap_hex", {hex5, hex4, hex3, hex2, hex1, hex0},
          {7'h0E, 7'h41, 7'h47, 7'h47, 7'h24, 7'h12});

    // reset in the middle of an entry abandons it
    step(2'b10);
    step(2'b11);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("midrst_state", dbg_state, 3'd0);
    check("midrst_clear", clear, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    n_incr_seen = 0;
    n_decr_seen = 0;
    step(2'b01);
    step(2'b00);
    step(2'b00);
    check("midrst_no_pulse", n_incr_seen + n_decr_seen, 0);

    // randomized passes and raw sensor noise
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    pass3(2'b10, 2'b11, 2'b01, 1'b1);
        2:       pass3(2'b01, 2'b11, 2'b10, 1'b1);
        default: step(2'($urandom_range(0, 3)));
      endcase
    end
    step(2'b00);
    step(2'b00);
    check("exp_q_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
